// File: rtl/alu4_div_ctrl.sv
// alu4_div_ctrl: sequential 4-bit unsigned restoring divider controller.
// Runs one subtract-compare per cycle on an external alu4. It produces the
// quotient and remainder and uses a start/busy/done handshake.
//
// Optional feature macro: ALU4_DIV_ZERO_CHK_EN.
//   Defined:     a zero divisor skips CALC and goes straight to DONE. The
//                outputs are quotient=F, remainder=dividend, div_by_zero=1.
//   Not defined: a zero divisor runs the normal four iterations, and
//                div_by_zero is tied to 0.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 operation request, sampled only in IDLE
//   dividend, divisor     operands, captured together with start
//   busy                  high in CALC and DONE
//   done                  one-cycle pulse while quotient/remainder are valid
//   quotient, remainder   result registers, held until the next result load
//   div_by_zero           flags a divide by zero (see macro above)
//   alu_a, alu_b, alu_op  operands and opcode driven to alu4
//   alu_result, alu_c     difference and no-borrow flag returned by alu4
module alu4_div_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_c
);

  localparam int unsigned W      = 4;
  localparam int unsigned CNT_W  = 2;
  localparam logic [2:0]  OP_SUB = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_n;
  logic [W-1:0]       r_q, q_q, d_q;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       shifted, r_next, q_next;
  logic               load_op, iterate, load_res, zero_hit;

  // Shift in the next dividend bit. R < 2^k after k steps, so no bit is lost.
  assign shifted = {r_q[W-2:0], q_q[W-1]};
  assign r_next  = alu_c ? alu_result : shifted;
  assign q_next  = {q_q[W-2:0], alu_c};

  assign alu_a  = shifted;
  assign alu_b  = d_q;
  assign alu_op = OP_SUB;

`ifdef ALU4_DIV_ZERO_CHK_EN
  assign zero_hit = (divisor == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_n  = state;
    load_op  = 1'b0;
    iterate  = 1'b0;
    load_res = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_op = 1'b1;
          state_n = zero_hit ? DONE : CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (cnt == CNT_W'(3)) begin
          load_res = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, working registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      if (load_op) begin
        q_q <= dividend;
        d_q <= divisor;
        r_q <= '0;
        cnt <= '0;
      end
      if (iterate) begin
        r_q <= r_next;
        q_q <= q_next;
        cnt <= cnt + CNT_W'(1);
      end
      if (load_res) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
      if (load_op && zero_hit) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end
  end

`ifdef ALU4_DIV_ZERO_CHK_EN
  // The divide-by-zero flag loads at the same point as the result registers.
  always_ff @(posedge clk) begin
    if (reset)                    div_by_zero <= 1'b0;
    else if (load_op && zero_hit) div_by_zero <= 1'b1;
    else if (load_res)            div_by_zero <= 1'b0;
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
